fsm_param: RTL and testbench

FSM_PARAM -- requirements
Module: fsm_param

---
 rtl/fsm_pkg.sv | 14 +
 rtl/fsm_param.sv | 94 +++++++++
 tb/tb_fsm_param.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
// Shared state encodings for the FIFO-monitor controller.
package fsm_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

endpackage

// File: rtl/fsm_param.sv
// FIFO-monitor controller: threshold configuration, idle/active tracking,
// and a sticky error state that records which FIFOs faulted.
module fsm_param
  import fsm_pkg::*;
#(
  parameter int unsigned NUM_FIFOS = 10,
  parameter int unsigned UMB_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [UMB_W-1:0]     umbral_alto,
  input  logic [UMB_W-1:0]     umbral_bajo,
  input  logic [NUM_FIFOS-1:0] FIFO_empty,
  input  logic [NUM_FIFOS-1:0] FIFO_error,
  output logic                 idle,
  output logic [UMB_W-1:0]     interno_alto,
  output logic [UMB_W-1:0]     interno_bajo,
  output logic [STATE_W-1:0]   estado,
  output logic                 error_out,
  output logic [NUM_FIFOS-1:0] error_fifo,
  output logic                 cfg_invalid
);

  state_e state_q;
  state_e state_n;

  logic all_empty_c;
  logic any_error_c;
  logic cfg_ok_c;

  // Input reductions and threshold-pair sanity check
  assign all_empty_c = &FIFO_empty;
  assign any_error_c = |FIFO_error;
  assign cfg_ok_c    = (umbral_bajo <= umbral_alto);

  assign estado = state_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state logic: error beats init, init beats empty-based moves
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_RESET: state_n = ST_INIT;
      ST_INIT, ST_IDLE, ST_ACTIVE: begin
        if (any_error_c) begin
          state_n = ST_ERROR;
        end else if (init) begin
          state_n = ST_INIT;
        end else if (all_empty_c) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_ACTIVE;
        end
      end
      ST_ERROR: state_n = ST_ERROR;
      default:  state_n = ST_RESET;
    endcase
  end

  // Registered outputs: status flags, committed thresholds, error capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle         <= 1'b0;
      error_out    <= 1'b0;
      cfg_invalid  <= 1'b0;
      error_fifo   <= '0;
      interno_alto <= '1;
      interno_bajo <= '0;
    end else begin
      idle        <= (state_n == ST_IDLE);
      error_out   <= (state_n == ST_ERROR);
      cfg_invalid <= (state_q == ST_INIT) && !cfg_ok_c;
      if ((state_q == ST_INIT) && cfg_ok_c) begin
        interno_alto <= umbral_alto;
        interno_bajo <= umbral_bajo;
      end
      if (state_q == ST_ERROR) begin
        error_fifo <= error_fifo | FIFO_error;
      end else if (state_n == ST_ERROR) begin
        error_fifo <= FIFO_error;
      end
    end
  end

endmodule

// File: tb/tb_fsm_param.sv
// Bench for fsm_param: a wide instance (10 FIFOs, 3-bit thresholds) and a
// narrow one (1 FIFO, 8-bit thresholds) driven with equivalent stimulus.
module tb_fsm_param;
  import fsm_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init;
  logic [2:0] alto, bajo;
  logic [9:0] empty, error;

  logic       idle_a, errout_a, cfginv_a;
  logic [2:0] ialto_a, ibajo_a, estado_a;
  logic [9:0] errf_a;

  logic [0:0] empty_b, error_b, errf_b;
  logic [7:0] alto_b, bajo_b, ialto_b, ibajo_b;
  logic       idle_b, errout_b, cfginv_b;
  logic [2:0] estado_b;

  int total = 0;
  int bad   = 0;

  // Narrow instance sees the reduced view of the wide stimulus
  assign empty_b = {&empty};
  assign error_b = {|error};
  assign alto_b  = 8'(alto);
  assign bajo_b  = 8'(bajo);

  always #5 clk = ~clk;

  fsm_param #(.NUM_FIFOS(10), .UMB_W(3)) dut_a (
    .clk(clk), .reset(reset), .init(init),
    .umbral_alto(alto), .umbral_bajo(bajo),
    .FIFO_empty(empty), .FIFO_error(error),
    .idle(idle_a), .interno_alto(ialto_a), .interno_bajo(ibajo_a),
    .estado(estado_a), .error_out(errout_a), .error_fifo(errf_a),
    .cfg_invalid(cfginv_a)
  );

  fsm_param #(.NUM_FIFOS(1), .UMB_W(8)) dut_b (
    .clk(clk), .reset(reset), .init(init),
    .umbral_alto(alto_b), .umbral_bajo(bajo_b),
    .FIFO_empty(empty_b), .FIFO_error(error_b),
    .idle(idle_b), .interno_alto(ialto_b), .interno_bajo(ibajo_b),
    .estado(estado_b), .error_out(errout_b), .error_fifo(errf_b),
    .cfg_invalid(cfginv_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state as a plain integer, rules taken straight from
  // the transition table (error > init > empties; ERROR absorbing).
  int         m_st;
  logic [2:0] m_alto_a, m_bajo_a;
  logic [7:0] m_alto_b, m_bajo_b;
  logic [9:0] m_errf_a;
  logic       m_errf_b;
  logic       m_inv;

  function automatic int model_next(input int s, input logic i,
                                    input logic [9:0] e, input logic [9:0] er);
    if (s == 4) return 4;
    if (s == 0) return 1;
    if ($countones(er) != 0) return 4;
    if (i) return 1;
    return ($countones(e) == 10) ? 2 : 3;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st     <= 0;
      m_alto_a <= 3'h7;
      m_bajo_a <= 3'h0;
      m_alto_b <= 8'hFF;
      m_bajo_b <= 8'h00;
      m_errf_a <= '0;
      m_errf_b <= 1'b0;
      m_inv    <= 1'b0;
    end else begin
      m_inv <= (m_st == 1) && (int'(bajo) > int'(alto));
      if ((m_st == 1) && (int'(bajo) <= int'(alto))) begin
        m_alto_a <= alto;
        m_bajo_a <= bajo;
        m_alto_b <= 8'(alto);
        m_bajo_b <= 8'(bajo);
      end
      if (m_st == 4) begin
        m_errf_a <= m_errf_a | error;
        m_errf_b <= m_errf_b | (error != 10'h0);
      end else if (model_next(m_st, init, empty, error) == 4) begin
        m_errf_a <= error;
        m_errf_b <= 1'b1;
      end
      m_st <= model_next(m_st, init, empty, error);
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    check("estado_a",  32'(estado_a), 32'(m_st));
    check("estado_b",  32'(estado_b), 32'(m_st));
    check("idle_a",    32'(idle_a),   32'(m_st == 2));
    check("idle_b",    32'(idle_b),   32'(m_st == 2));
    check("errout_a",  32'(errout_a), 32'(m_st == 4));
    check("errout_b",  32'(errout_b), 32'(m_st == 4));
    check("cfginv_a",  32'(cfginv_a), 32'(m_inv));
    check("cfginv_b",  32'(cfginv_b), 32'(m_inv));
    check("ialto_a",   32'(ialto_a),  32'(m_alto_a));
    check("ibajo_a",   32'(ibajo_a),  32'(m_bajo_a));
    check("ialto_b",   32'(ialto_b),  32'(m_alto_b));
    check("ibajo_b",   32'(ibajo_b),  32'(m_bajo_b));
    check("errf_a",    32'(errf_a),   32'(m_errf_a));
    check("errf_b",    32'(errf_b),   32'(m_errf_b));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Directed scenario with hand-computed literal expectations
  initial begin
    init  = 1'b0;
    alto  = 3'd0;
    bajo  = 3'd0;
    empty = '1;
    error = '0;
    #1 reset = 1'b1;

    @(negedge clk); #1;
    check("rst_estado", 32'(estado_a), 32'd0);
    check("rst_ialto_a", 32'(ialto_a), 32'h7);
    check("rst_ibajo_a", 32'(ibajo_a), 32'h0);
    check("rst_ialto_b", 32'(ialto_b), 32'hFF);
    check("rst_idle", 32'(idle_a), 32'd0);

    // Release mid-cycle with init held high and a valid 5/2 pair
    init = 1'b1; alto = 3'd5; bajo = 3'd2;
    reset = 1'b0;
    @(negedge clk); #1;
    check("seq_1st", 32'(estado_a), 32'd1);
    @(negedge clk); #1;
    check("seq_2nd", 32'(estado_a), 32'd1);
    check("load_alto", 32'(ialto_a), 32'd5);
    check("load_bajo", 32'(ibajo_a), 32'd2);
    init = 1'b0;
    @(negedge clk); #1;
    check("seq_idle", 32'(estado_a), 32'd2);
    check("seq_idle_b", 32'(estado_b), 32'd2);
    check("idle_flag", 32'(idle_a), 32'd1);
    check("ialto_b_5", 32'(ialto_b), 32'd5);

    // Back to INIT; reject an inverted pair, then accept an equal pair
    init = 1'b1;
    @(negedge clk); #1;
    check("reinit", 32'(estado_a), 32'd1);
    alto = 3'd1; bajo = 3'd4;
    @(negedge clk); #1;
    check("inv_pulse", 32'(cfginv_a), 32'd1);
    check("inv_keep_alto", 32'(ialto_a), 32'd5);
    check("inv_keep_bajo", 32'(ibajo_a), 32'd2);
    alto = 3'd3; bajo = 3'd3;
    @(negedge clk); #1;
    check("inv_drop", 32'(cfginv_a), 32'd0);
    check("eq_alto", 32'(ialto_a), 32'd3);
    check("eq_bajo", 32'(ibajo_a), 32'd3);
    alto = 3'd5; bajo = 3'd2; init = 1'b0;
    @(negedge clk); #1;
    check("back_idle", 32'(estado_a), 32'd2);
    check("relo_alto", 32'(ialto_a), 32'd5);

    // IDLE <-> ACTIVE on FIFO_empty[3]
    empty[3] = 1'b0;
    @(negedge clk); #1;
    check("to_active", 32'(estado_a), 32'd3);
    check("active_idle0", 32'(idle_a), 32'd0);
    empty[3] = 1'b1;
    @(negedge clk); #1;
    check("to_idle", 32'(estado_a), 32'd2);
    check("idle_again", 32'(idle_a), 32'd1);

    // Error with simultaneous init: ERROR wins and is sticky
    empty[3] = 1'b0;
    @(negedge clk); #1;
    check("active2", 32'(estado_a), 32'd3);
    error[7] = 1'b1; init = 1'b1;
    @(negedge clk); #1;
    check("err_state", 32'(estado_a), 32'd4);
    check("err_out", 32'(errout_a), 32'd1);
    check("err_fifo", 32'(errf_a), 32'h080);
    check("err_fifo_b", 32'(errf_b), 32'd1);
    error = '0; init = 1'b0; empty[5] = 1'b0;
    @(negedge clk); #1;
    check("err_sticky1", 32'(estado_a), 32'd4);
    init = 1'b1; empty = '1; error[1] = 1'b1;
    @(negedge clk); #1;
    check("err_sticky2", 32'(estado_a), 32'd4);
    check("err_accum", 32'(errf_a), 32'h082);
    init = 1'b0; error = '0;
    @(negedge clk); #1;
    check("err_sticky3", 32'(estado_b), 32'd4);

    // Asynchronous reset well away from any rising edge
    #1 reset = 1'b1;
    #1;
    check("arst_estado", 32'(estado_a), 32'd0);
    check("arst_errf", 32'(errf_a), 32'd0);
    check("arst_alto", 32'(ialto_a), 32'd7);
    check("arst_bajo", 32'(ibajo_a), 32'd0);
    check("arst_errout", 32'(errout_a), 32'd0);
    check("arst_alto_b", 32'(ialto_b), 32'hFF);
    check("arst_estado_b", 32'(estado_b), 32'd0);

    // Error raised while in INIT after a fresh release
    @(negedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    check("rel2_init", 32'(estado_a), 32'd1);
    error[0] = 1'b1;
    @(negedge clk); #1;
    check("init_err", 32'(estado_a), 32'd4);
    check("init_errf", 32'(errf_a), 32'h001);
    check("init_err_alto", 32'(ialto_a), 32'd5);
    error = '0;
    @(negedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
